// File: rtl/yari_mem_arb_if.sv
// yari_mem_arb_if: channel request/response and memory-side bus of the arbiter
interface yari_mem_arb_if #(
  parameter int NCH  = 2,
  parameter int ID_W = 2
);
  logic [NCH*30-1:0] ch_address;
  logic [NCH-1:0]    ch_read;
  logic [NCH-1:0]    ch_write;
  logic [NCH*32-1:0] ch_writedata;
  logic [NCH*4-1:0]  ch_writedatamask;
  logic [NCH-1:0]    ch_waitrequest;
  logic [31:0]       ch_readdata;
  logic [NCH-1:0]    ch_readdatavalid;
  logic              mem_waitrequest;
  logic [ID_W-1:0]   mem_id;
  logic [29:0]       mem_address;
  logic              mem_read;
  logic              mem_write;
  logic [31:0]       mem_writedata;
  logic [3:0]        mem_writedatamask;
  logic [31:0]       mem_readdata;
  logic [ID_W-1:0]   mem_readdataid;
  logic              err_unexpected;
  modport slave (
    input  ch_address, ch_read, ch_write, ch_writedata, ch_writedatamask,
           mem_waitrequest, mem_readdata, mem_readdataid,
    output ch_waitrequest, ch_readdata, ch_readdatavalid, mem_id, mem_address,
           mem_read, mem_write, mem_writedata, mem_writedatamask, err_unexpected
  );
  modport master (
    output ch_address, ch_read, ch_write, ch_writedata, ch_writedatamask,
           mem_waitrequest, mem_readdata, mem_readdataid,
    input  ch_waitrequest, ch_readdata, ch_readdatavalid, mem_id, mem_address,
           mem_read, mem_write, mem_writedata, mem_writedatamask, err_unexpected
  );
endinterface

// File: rtl/yari_mem_arb.sv
// yari_mem_arb: zero-latency multi-channel memory arbiter with grant lock under
// memory stall and per-channel outstanding-read tracking
module yari_mem_arb #(
  parameter int NCH     = 2,
  parameter int ID_W    = 2,
  parameter int MODE    = 0,
  parameter int MAX_OUT = 4
) (
  input logic clock,
  input logic rst,
  yari_mem_arb_if.slave bus
);
  localparam int PW = $clog2(NCH);
  logic [NCH-1:0][3:0] outstanding, outstanding_n;
  logic [PW-1:0] rr_ptr, rr_ptr_n, lock_g, lock_g_n, gnt, cand;
  logic lock_v, lock_v_n, err, err_n, gnt_v, locked, accept;
  logic [NCH-1:0] elig, strobe, inc, dec;
  always_ff @(posedge clock) begin
    if (rst) begin
      outstanding <= '0;
      rr_ptr <= '0;
      lock_v <= 1'b0;
      lock_g <= '0;
      err <= 1'b0;
    end else begin
      outstanding <= outstanding_n;
      rr_ptr <= rr_ptr_n;
      lock_v <= lock_v_n;
      lock_g <= lock_g_n;
      err <= err_n;
    end
  end
  // a held grant survives only while its owner keeps strobing and reset is low
  always_comb begin
    strobe = bus.ch_read | bus.ch_write;
    elig = '0;
    for (int i = 0; i < NCH; i++)
      elig[i] = bus.ch_write[i] | (bus.ch_read[i] & (outstanding[i] < 4'(MAX_OUT)));
    locked = ~rst & lock_v & strobe[lock_g];
    gnt_v = locked;
    gnt = locked ? lock_g : '0;
    cand = '0;
    for (int k = 0; k < NCH; k++) begin
      cand = PW'(((MODE != 0) ? int'(rr_ptr) + k : k) % NCH);
      if (!gnt_v && elig[cand]) begin
        gnt_v = 1'b1;
        gnt = cand;
      end
    end
  end
  always_comb begin
    accept = gnt_v & ~bus.mem_waitrequest;
    lock_v_n = gnt_v & bus.mem_waitrequest;
    lock_g_n = gnt;
    rr_ptr_n = accept ? ((gnt == PW'(NCH - 1)) ? '0 : gnt + 1'b1) : rr_ptr;
    err_n = err | (bus.mem_readdataid > ID_W'(NCH));
    inc = '0;
    dec = '0;
    outstanding_n = outstanding;
    for (int i = 0; i < NCH; i++) begin
      inc[i] = accept && gnt == PW'(i) && bus.ch_read[i];
      dec[i] = bus.mem_readdataid == ID_W'(i + 1) && outstanding[i] != 4'd0;
      if (bus.mem_readdataid == ID_W'(i + 1) && outstanding[i] == 4'd0) err_n = 1'b1;
      outstanding_n[i] = outstanding[i] + {3'b0, inc[i]} - {3'b0, dec[i]};
    end
  end
  always_comb begin
    bus.mem_id = gnt_v ? ID_W'(gnt) + ID_W'(1) : '0;
    bus.mem_address = gnt_v ? bus.ch_address[30*gnt +: 30] : '0;
    bus.mem_read = gnt_v ? bus.ch_read[gnt] : 1'b0;
    bus.mem_write = gnt_v ? bus.ch_write[gnt] : 1'b0;
    bus.mem_writedata = gnt_v ? bus.ch_writedata[32*gnt +: 32] : '0;
    bus.mem_writedatamask = gnt_v ? bus.ch_writedatamask[4*gnt +: 4] : '0;
    bus.ch_readdata = bus.mem_readdata;
    bus.err_unexpected = err;
    bus.ch_waitrequest = '0;
    bus.ch_readdatavalid = '0;
    for (int i = 0; i < NCH; i++) begin
      bus.ch_waitrequest[i] = ~(gnt_v && gnt == PW'(i)) | bus.mem_waitrequest;
      bus.ch_readdatavalid[i] = bus.mem_readdataid == ID_W'(i + 1);
    end
  end
endmodule

// File: doc/yari_mem_arb.md
YARI_MEM_ARB -- requirements
Module: yari_mem_arb

Interface
REQ-001 Parameter NCH, default 2: number of requesting channels, legal 2..4; channel i has memory id i+1, and id 0 means idle/invalid.
REQ-002 Parameter ID_W, default 2: width of mem_id/mem_readdataid; must satisfy 2**ID_W > NCH.
REQ-003 Parameter MODE, default 0: 0 = fixed priority (lowest index wins), 1 = round-robin.
REQ-004 Parameter MAX_OUT, default 4: maximum outstanding reads per channel, legal 1..15.
REQ-005 One clock; reset is synchronous and active-high.
REQ-006 clock  in  1  system clock; all state changes on its rising edge.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 ch_address  in  NCH*30  word address; channel i occupies bits [30i+29:30i].
REQ-009 ch_read  in  NCH  read strobe per channel.
REQ-010 ch_write  in  NCH  write strobe per channel; read and write are never both high on one channel.
REQ-011 ch_writedata  in  NCH*32  write data per channel.
REQ-012 ch_writedatamask  in  NCH*4  byte enables per channel.
REQ-013 ch_waitrequest  out  NCH  per-channel stall; the request is accepted in a cycle where the strobe is high and this bit is low.
REQ-014 ch_readdata  out  32  equals mem_readdata, shared by all channels.
REQ-015 ch_readdatavalid  out  NCH  bit i high iff mem_readdataid == i+1.
REQ-016 mem_waitrequest  in  1  memory stall.
REQ-017 mem_id  out  ID_W  id of the granted channel, or 0 when no channel is granted.
REQ-018 mem_address / mem_read / mem_write / mem_writedata / mem_writedatamask  out  30/1/1/32/4  signals of the granted channel; all zero when no channel is granted.
REQ-019 mem_readdata  in  32  returned read data.
REQ-020 mem_readdataid  in  ID_W  id of the returned data; 0 means no return this cycle.
REQ-021 err_unexpected  out  1  sticky flag: a read return arrived for a channel with zero outstanding reads, or carried an id greater than NCH.

Function
REQ-022 outstanding[i] is a per-channel counter of accepted reads not yet returned; it is 0..MAX_OUT, 4 bits wide.
REQ-023 Channel i is eligible iff (ch_write[i], or ch_read[i] with outstanding[i] < MAX_OUT).
REQ-024 Arbitration is combinational with zero-cycle latency: the grant and the mem_* outputs are valid in the same cycle as the request.
REQ-025 Lock: if the grant was to channel g last cycle, mem_waitrequest was high, and g still strobes, the grant stays on g regardless of other requests.
REQ-026 When not locked, MODE 0 grants the lowest-index eligible channel.
REQ-027 When not locked, MODE 1 grants the first eligible channel found searching upward from rr_ptr, wrapping modulo NCH.
REQ-028 rr_ptr updates only on an accepted transfer, to (granted+1) mod NCH, wrapping from NCH-1 to 0; MODE 0 ignores rr_ptr.
REQ-029 ch_waitrequest[i] = ~(grant==i) | mem_waitrequest.
REQ-030 A read blocked by MAX_OUT sees waitrequest high and is never granted until a return frees a slot.
REQ-031 Accepted read on channel i: outstanding[i] increments at the next edge.
REQ-032 Read return with id i+1: outstanding[i] decrements at the next edge.
REQ-033 An accept and a return on the same channel in the same cycle leave outstanding[i] unchanged.
REQ-034 A return with outstanding[i]==0, or with id > NCH, leaves all counters unchanged and sets err_unexpected.
REQ-035 Read returns are routed to ch_readdatavalid combinationally, whether or not a request is pending.
REQ-036 Writes do not touch the outstanding counters.
REQ-037 A channel that drops its strobe while locked is permitted but illegal per protocol; the lock clears and arbitration restarts in the same cycle.

Reset
REQ-038 While rst is high: outstanding = 0, rr_ptr = 0, lock cleared, err_unexpected = 0.
REQ-039 The grant path and mem_* outputs remain combinational during reset.
REQ-040 Reset in the middle of a locked transfer drops the lock.
REQ-041 Returns that arrive after reset for pre-reset reads hit zero counters and set err_unexpected; software treats this as expected after a reset.

Verification
REQ-042 MODE 0, NCH=2, ch_read=2'b11, mem_waitrequest=0 -> mem_id=1, ch_waitrequest=2'b10; channel 1 is granted only after channel 0 deasserts.
REQ-043 MODE 1, NCH=3, all channels reading continuously, no waits -> mem_id sequence 1,2,3,1,2,3.
REQ-044 Lock: channel 1 granted with mem_waitrequest=1 for 3 cycles while channel 0 then requests -> grant stays on channel 1 until accepted; channel 0 is served next cycle.
REQ-045 MAX_OUT=2: channel 0 issues 3 reads with no return -> third read has waitrequest high; return id=1 -> third read accepted the cycle after.
REQ-046 Same-cycle accept and return on channel 0 with outstanding=1 -> outstanding stays 1; a return with id=3 when NCH=2 -> err_unexpected=1, held until rst.
